// File: rtl/fp_div_sched.sv
// fp_div_sched: issue/retire stage wrapped around a combinational binary64 divider.
// Operand pairs are queued in a FIFO, driven onto the divider one at a time and
// held for SETTLE_CYC cycles; the quotient is captured together with
// IEEE-754 exception flags and the user tag.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           operand pair handshake (in_a, in_b, in_tag)
//   div_a, div_b, div_result    connection to the fp_div datapath
//   out_valid/out_ready         result handshake (out_result, out_tag,
//                               out_invalid, out_dz)
//   busy                        work queued or in flight
module fp_div_sched #(
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [63:0]      div_a,
    output logic [63:0]      div_b,
    input  logic [63:0]      div_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_invalid,
    output logic             out_dz,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SET_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    // Operand storage (data only; validity is tracked by the pointers)
    logic [63:0]      mem_a_q   [DEPTH];
    logic [63:0]      mem_b_q   [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [63:0]      div_a_q, div_a_d;
    logic [63:0]      div_b_q, div_b_d;
    logic [TAG_W-1:0] op_tag_q, op_tag_d;

    logic [63:0]      out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_valid_q, out_valid_d;
    logic             out_invalid_q, out_invalid_d;
    logic             out_dz_q, out_dz_d;

    logic push;
    logic pop;

    // Field classification of the held operands
    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;
    logic flag_invalid, flag_dz;

    always_comb begin
        a_zero = (div_a_q[62:52] == 11'h000) && (div_a_q[51:0] == 52'd0);
        a_inf  = (div_a_q[62:52] == 11'h7FF) && (div_a_q[51:0] == 52'd0);
        a_nan  = (div_a_q[62:52] == 11'h7FF) && (div_a_q[51:0] != 52'd0);
        b_zero = (div_b_q[62:52] == 11'h000) && (div_b_q[51:0] == 52'd0);
        b_inf  = (div_b_q[62:52] == 11'h7FF) && (div_b_q[51:0] == 52'd0);
        b_nan  = (div_b_q[62:52] == 11'h7FF) && (div_b_q[51:0] != 52'd0);

        flag_invalid = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
        flag_dz      = b_zero & ~a_zero & ~a_inf & ~a_nan;
    end

    // in_ready deliberately ignores a same-cycle pop
    assign in_ready = (count_q != FULL);
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        div_a_d       = div_a_q;
        div_b_d       = div_b_q;
        op_tag_d      = op_tag_q;
        out_result_d  = out_result_q;
        out_tag_d     = out_tag_q;
        out_valid_d   = out_valid_q;
        out_invalid_d = out_invalid_q;
        out_dz_d      = out_dz_q;
        pop           = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - SET_ONE;
                end else begin
                    out_result_d  = div_result;
                    out_tag_d     = op_tag_q;
                    out_invalid_d = flag_invalid;
                    out_dz_d      = flag_dz;
                    out_valid_d   = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    // Result consumed; chain straight into the next op if queued
                    out_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            div_a_d  = mem_a_q[rd_ptr_q];
            div_b_d  = mem_b_q[rd_ptr_q];
            op_tag_d = mem_tag_q[rd_ptr_q];
            cnt_d    = SET_LOAD;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q]   <= in_a;
            mem_b_q[wr_ptr_q]   <= in_b;
            mem_tag_q[wr_ptr_q] <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            div_a_q       <= '0;
            div_b_q       <= '0;
            op_tag_q      <= '0;
            out_result_q  <= '0;
            out_tag_q     <= '0;
            out_valid_q   <= 1'b0;
            out_invalid_q <= 1'b0;
            out_dz_q      <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_a_q       <= div_a_d;
            div_b_q       <= div_b_d;
            op_tag_q      <= op_tag_d;
            out_result_q  <= out_result_d;
            out_tag_q     <= out_tag_d;
            out_valid_q   <= out_valid_d;
            out_invalid_q <= out_invalid_d;
            out_dz_q      <= out_dz_d;
        end
    end

    assign div_a       = div_a_q;
    assign div_b       = div_b_q;
    assign out_result  = out_result_q;
    assign out_tag     = out_tag_q;
    assign out_valid   = out_valid_q;
    assign out_invalid = out_invalid_q;
    assign out_dz      = out_dz_q;
    assign busy        = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_div_sched.sv
// tb_fp_div_sched: self-checking bench for fp_div_sched with a behavioural
// stand-in for the fp_div datapath and a queue-based result scoreboard.
module tb_fp_div_sched;

    localparam int DEPTH      = 4;
    localparam int SETTLE_CYC = 2;
    localparam int TAG_W      = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic [63:0]      div_a;
    logic [63:0]      div_b;
    logic [63:0]      div_result;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_invalid;
    logic             out_dz;
    logic             busy;

    fp_div_sched #(
        .DEPTH(DEPTH),
        .SETTLE_CYC(SETTLE_CYC),
        .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_tag(in_tag),
        .div_a(div_a),
        .div_b(div_b),
        .div_result(div_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_tag(out_tag),
        .out_invalid(out_invalid),
        .out_dz(out_dz),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
        logic             inv;
        logic             dz;
    } exp_t;

    typedef struct {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [TAG_W-1:0] tag;
        logic [63:0]      res;
        logic             inv;
        logic             dz;
    } vec_t;

    exp_t sb[$];
    int   hs_cyc[$];

    function automatic logic is_zero(input logic [63:0] x);
        return x[62:0] == 63'd0;
    endfunction

    function automatic logic is_inf(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
    endfunction

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    // Stand-in for the combinational divider
    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b);
        if (is_nan(a) || is_nan(b)) return 64'h7FF8000000000000;
        if ((is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b)))
            return 64'h7FF8000000000000;
        if (is_zero(b)) return {a[63] ^ b[63], 11'h7FF, 52'd0};
        return $realtobits($bitstoreal(a) / $bitstoreal(b));
    endfunction

    function automatic exp_t mk_exp(input logic [63:0] a, input logic [63:0] b,
                                    input logic [TAG_W-1:0] t);
        exp_t e;
        e.res = ref_div(a, b);
        e.tag = t;
        e.inv = is_nan(a) | is_nan(b) | (is_zero(a) & is_zero(b)) | (is_inf(a) & is_inf(b));
        e.dz  = is_zero(b) & ~is_zero(a) & ~is_inf(a) & ~is_nan(a);
        return e;
    endfunction

    function automatic logic [63:0] rnd_op();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 5))
            0: return {s, 63'd0};
            1: return {s, 11'h7FF, 52'd0};
            2: return {s, 11'h7FF, 20'($urandom), 32'($urandom) | 32'd1};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    always_comb div_result = ref_div(div_a, div_b);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result monitor: every accepted result must match the scoreboard head
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected_result", 64'(out_tag), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_result", out_result, e.res);
                chk("mon_tag", 64'(out_tag), 64'(e.tag));
                chk("mon_invalid", 64'(out_invalid), 64'(e.inv));
                chk("mon_dz", 64'(out_dz), 64'(e.dz));
            end
            hs_cyc.push_back(cyc);
        end
    end

    // One clock of stimulus; called at a negedge, returns at the next negedge
    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] t, input logic rdy, output logic acc);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
        out_ready = rdy;
        #1;
        acc = v && in_ready;
        if (acc) sb.push_back(mk_exp(a, b, t));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int  n;
        logic got;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            step(1'b0, 64'd0, 64'd0, '0, 1'b1, got);
            n++;
        end
        chk("drain_timeout", 64'(n < 100), 64'd1);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic single_op(input vec_t v);
        int   n;
        logic got;
        step(1'b1, v.a, v.b, v.tag, 1'b1, got);
        chk("single_accept", 64'(got), 64'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            step(1'b0, 64'd0, 64'd0, '0, 1'b1, got);
            n++;
        end
        chk("single_latency", 64'(n), 64'(SETTLE_CYC + 1));
        chk("single_result", out_result, v.res);
        chk("single_tag", 64'(out_tag), 64'(v.tag));
        chk("single_invalid", 64'(out_invalid), 64'(v.inv));
        chk("single_dz", 64'(out_dz), 64'(v.dz));
        step(1'b0, 64'd0, 64'd0, '0, 1'b1, got);
        chk("single_busy_after", 64'(busy), 64'd0);
        chk("single_valid_after", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[10];
        logic        got;
        int          acc;
        int          n;
        logic [63:0] pa[6];
        logic [63:0] pb[6];
        exp_t        e0;

        vecs[0] = '{64'h4024000000000000, 64'h4000000000000000, 4'd3, 64'h4014000000000000, 1'b0, 1'b0};
        vecs[1] = '{64'h0000000000000000, 64'h0000000000000000, 4'd1, 64'h7FF8000000000000, 1'b1, 1'b0};
        vecs[2] = '{64'h3FF0000000000000, 64'h0000000000000000, 4'd2, 64'h7FF0000000000000, 1'b0, 1'b1};
        vecs[3] = '{64'h7FF8000000000000, 64'h4000000000000000, 4'd4, 64'h7FF8000000000000, 1'b1, 1'b0};
        vecs[4] = '{64'h7FF0000000000000, 64'h7FF0000000000000, 4'd5, 64'h7FF8000000000000, 1'b1, 1'b0};
        vecs[5] = '{64'h7FF0000000000000, 64'h0000000000000000, 4'd6, 64'h7FF0000000000000, 1'b0, 1'b0};
        vecs[6] = '{64'h4018000000000000, 64'h7FF0000000000000, 4'd7, 64'h0000000000000000, 1'b0, 1'b0};
        vecs[7] = '{64'hBFF0000000000000, 64'h8000000000000000, 4'd8, 64'h7FF0000000000000, 1'b0, 1'b1};
        vecs[8] = '{64'h3FF0000000000000, 64'h4008000000000000, 4'd9, 64'h3FD5555555555555, 1'b0, 1'b0};
        vecs[9] = '{64'h0000000000000000, 64'h3FF0000000000000, 4'd10, 64'h0000000000000000, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_div_a", div_a, 64'd0);
        chk("rst_div_b", div_b, 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_flags", 64'({out_invalid, out_dz}), 64'd0);

        for (int i = 0; i < 10; i++) single_op(vecs[i]);

        // Fill with the output stalled: one op in HOLD, DEPTH queued
        for (int i = 0; i < 6; i++) begin
            pa[i] = rnd_op();
            pb[i] = rnd_op();
        end
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            step(acc < 6, pa[acc % 6], pb[acc % 6], TAG_W'(acc % 6), 1'b0, got);
            if (got) acc++;
        end
        chk("fill_accepted", 64'(acc), 64'd5);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_out_valid", 64'(out_valid), 64'd1);

        e0 = sb[0];
        for (int i = 0; i < 10; i++) begin
            step(1'b1, pa[5], pb[5], TAG_W'(5), 1'b0, got);
            chk("stall_no_accept", 64'(got), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_result", out_result, e0.res);
            chk("stall_tag", 64'(out_tag), 64'(e0.tag));
            chk("stall_flags", 64'({out_invalid, out_dz}), 64'({e0.inv, e0.dz}));
        end

        hs_cyc.delete();
        n = 0;
        while ((acc < 6 || sb.size() != 0 || busy) && n < 100) begin
            step(acc < 6, pa[acc % 6], pb[acc % 6], TAG_W'(acc % 6), 1'b1, got);
            if (got) acc++;
            n++;
        end
        chk("release_timeout", 64'(n < 100), 64'd1);
        chk("release_count", 64'(hs_cyc.size()), 64'd6);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("release_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(SETTLE_CYC + 1));

        // Simultaneous push and pop with DEPTH-1 entries queued
        acc = 0;
        n = 0;
        while (acc < DEPTH && n < 20) begin
            step(1'b1, rnd_op(), rnd_op(), TAG_W'(acc), 1'b0, got);
            if (got) acc++;
            n++;
        end
        chk("pp_prefill", 64'(acc), 64'(DEPTH));
        for (int k = 0; k < 3 * DEPTH; k++) begin
            n = 0;
            while (!out_valid && n < 20) begin
                step(1'b0, 64'd0, 64'd0, '0, 1'b0, got);
                n++;
            end
            chk("pp_wait_valid", 64'(out_valid), 64'd1);
            step(1'b1, rnd_op(), rnd_op(), TAG_W'(k + DEPTH), 1'b1, got);
            chk("pp_push", 64'(got), 64'd1);
            chk("pp_in_ready", 64'(in_ready), 64'd1);
            chk("pp_busy", 64'(busy), 64'd1);
        end
        drain();

        // Reset while an op is settling with two more queued
        for (int i = 0; i < 3; i++) step(1'b1, rnd_op(), rnd_op(), TAG_W'(i + 12), 1'b1, got);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_div_a", div_a, 64'd0);
        chk("midrst_div_b", div_b, 64'd0);
        single_op(vecs[8]);

        // Randomized traffic with random backpressure
        begin
            logic             pv;
            logic [63:0]      ra;
            logic [63:0]      rb;
            logic [TAG_W-1:0] rt;
            pv = 1'b0;
            ra = '0;
            rb = '0;
            rt = '0;
            for (int i = 0; i < 600; i++) begin
                if (!pv && $urandom_range(0, 9) < 6) begin
                    pv = 1'b1;
                    ra = rnd_op();
                    rb = rnd_op();
                    rt = TAG_W'($urandom);
                end
                step(pv, ra, rb, rt, $urandom_range(0, 9) < 7, got);
                if (got) pv = 1'b0;
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
